array_result_reader: RTL and testbench
======================================

Name: array_result_reader

Overview:
Drains the 4x4 systolic array's packed accumulator bus (16 x ACC_WIDTH results) into a single-element valid/ready stream for the result writeback path. On a capture pulse it snapshots the whole bus into a local buffer, freeing the array for the next tile at once. It then emits the 16 results one per accepted beat, in row-major or column-major order, tagged with row/col coordinates and a last flag.

Parameters:
ACC_WIDTH, 16, bit-width of one accumulator result; matches the array's accumulation width.
ROWS, 4, PE rows; fixed at 4 for this revision.
COLS, 4, PE columns; fixed at 4 for this revision.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous, active-low reset
array_data_out  input  ACC_WIDTH*16  packed PE results; element i at bits [ACC_WIDTH*(i+1)-1 : ACC_WIDTH*i], i = row*4+col
capture  input  1  request to snapshot array_data_out and start a drain
col_major  input  1  drain order, sampled only when a capture is accepted; 0 = row-major, 1 = column-major
out_data  output  ACC_WIDTH  current result element
out_row  output  2  PE row of out_data
out_col  output  2  PE column of out_data
out_valid  output  1  out_data/out_row/out_col/out_last are valid
out_ready  input  1  downstream accepts the beat
out_last  output  1  current beat is the 16th element of the drain
busy  output  1  high while in STREAM
overrun  output  1  sticky: a capture was dropped
clr_overrun  input  1  clears overrun

Behaviour:
- Reset (async assert, sync use after deassert):
  - state=IDLE, beat counter=0, snapshot buffer=0, order reg=0.
  - out_valid=0, out_last=0, busy=0, overrun=0, out_data=0, out_row=0, out_col=0.
  - Reset asserted mid-drain aborts the drain. No further beats are emitted from the old snapshot.
- FSM has two states, IDLE and STREAM.
- Capture acceptance:
  - A capture is accepted when state==IDLE and capture=1, or when the final beat is accepted in the same cycle (out_valid & out_ready & out_last) and capture=1.
  - On acceptance, the buffer loads all 16 elements of array_data_out, the order reg loads col_major, the counter goes to 0, and state becomes STREAM.
- Latency: out_valid=1 in the cycle after the accepting edge, presenting beat 0.
- Beat mapping, for beat k (0..15):
  - Row-major: linear index L=k.
  - Column-major: L=(k%4)*4 + k/4.
  - out_row=L/4, out_col=L%4, out_data=buffer[L].
  - Values pass through bit-exact; there is no arithmetic.
- Handshake:
  - A beat transfers when out_valid & out_ready. The counter then increments.
  - While out_valid=1 and out_ready=0, all out_* hold stable. out_valid never drops before the transfer.
  - out_last=1 exactly when counter==15 and out_valid=1.
- Drain completion:
  - When beat 15 transfers with no new capture, state returns to IDLE and out_valid=0 next cycle.
  - If a capture coincides with the beat-15 transfer, the next cycle shows out_valid=1, beat 0 of the new snapshot. There is no bubble.
- Dropped capture: capture=1 in STREAM, outside the final-transfer cycle, is ignored and sets overrun=1 next cycle.
- overrun clearing:
  - clr_overrun=1 clears overrun next cycle.
  - A simultaneous drop and clear leaves overrun=1 (set wins).
- busy = (state==STREAM), driven from a register.
- out_ready is ignored while out_valid=0.
- A full drain takes a minimum of 16 cycles after the capture edge when out_ready is held at 1.

Decomposition:
- Shared package/defines holds:
  - ACC_WIDTH (reuse the existing global accumulation-width define).
  - ARRAY_DIM=4 and NUM_PE=16.
  - State encodings IDLE=1'b0 and STREAM=1'b1.
- One natural sub-module, array_index_map: a combinational mapping of (k, col_major) to (L, row, col). The bench reuses it as its reference model.

Test Plan:
- Single drain, row-major:
  - Stimulus: element i=16'h0100+i, capture one cycle, col_major=0, out_ready=1.
  - Required response: out_valid rises 1 cycle after the capture edge. Beats are 0x0100..0x010F in order. Row/col count (0,0),(0,1)..(3,3). out_last is set on beat 15 only. busy falls after beat 15.
- Column-major drain:
  - Stimulus: same data, col_major=1.
  - Required response: beats are 0x0100,0x0104,0x0108,0x010C,0x0101..0x010F. Row/col count (0,0),(1,0),(2,0),(3,0),(0,1)...
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 repeating, and array_data_out changes every cycle after capture.
  - Required response: out_* stay stable while stalled. The emitted values equal the snapshot taken at the capture edge.
- Back-to-back and overrun:
  - Stimulus: capture held during beats 3..14; capture asserted on the beat-15 transfer cycle with new data 16'hA000+i.
  - Required response: overrun=1. The next cycle presents 0xA000 with out_valid continuous. clr_overrun then gives overrun=0.
- Reset mid-drain:
  - Stimulus: assert rst_n=0 at beat 7, then release.
  - Required response: outputs 0 immediately, with no clock needed. IDLE follows and no beats are emitted until a new capture.
- Edge values:
  - Stimulus: elements 16'hFFFF and 16'h8000 at L=0 and L=15.
  - Required response: emitted bit-exact, with no sign handling.

Source files
------------

// File: rtl/array_result_reader_pkg.sv
// Shared constants for the systolic-array result reader: accumulator width,
// array geometry and the drain FSM state encodings.
package array_result_reader_pkg;

  // Accumulator width of the array this reader drains.
  localparam int ACC_WIDTH = 16;

  // Array geometry; this revision is a fixed 4x4 array.
  localparam int ARRAY_DIM = 4;
  localparam int NUM_PE    = ARRAY_DIM * ARRAY_DIM;

  // Drain FSM encodings.
  localparam logic IDLE   = 1'b0;
  localparam logic STREAM = 1'b1;

endpackage

// File: rtl/array_result_reader_index_map.sv
// Maps a drain beat number k (0..15) and the drain order to the linear PE
// index L = row*4 + col plus the row/column coordinates of that PE.
// Row-major:    L = k
// Column-major: L = (k % 4) * 4 + k / 4, i.e. the two 2-bit halves swapped.
module array_index_map (
  input  logic       col_major,
  input  logic [3:0] k,
  output logic [3:0] lin,
  output logic [1:0] row,
  output logic [1:0] col
);

  // Pure bit rearrangement: no arithmetic is needed for a 4x4 array.
  always_comb begin
    lin = k;
    if (col_major) begin
      lin = {k[1:0], k[3:2]};
    end
    row = lin[3:2];
    col = lin[1:0];
  end

endmodule

// File: rtl/array_result_reader.sv
// Drains the packed 4x4 accumulator bus into a one-element valid/ready
// stream. A capture snapshots the whole bus into a local buffer so the array
// is free immediately; the buffer is then streamed one result per accepted
// beat in row-major or column-major order, tagged with row/col and last.
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both 1. Once out_valid is 1 it stays 1, and out_data,
// out_row, out_col and out_last stay stable, until that transfer happens.
// out_ready has no effect while out_valid is 0.
module array_result_reader #(
  parameter int ACC_WIDTH = array_result_reader_pkg::ACC_WIDTH,
  parameter int ROWS      = 4,
  parameter int COLS      = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ACC_WIDTH*ROWS*COLS-1:0]  array_data_out,
  input  logic                            capture,
  input  logic                            col_major,
  output logic [ACC_WIDTH-1:0]            out_data,
  output logic [1:0]                      out_row,
  output logic [1:0]                      out_col,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            overrun,
  input  logic                            clr_overrun
);

  import array_result_reader_pkg::*;

  localparam int NUM_ELEM = ROWS * COLS;

  // FSM state doubles as the busy flag and as the out_valid source, so every
  // stream qualifier comes straight from a flop.
  logic                 state;
  logic [3:0]           beat;
  logic                 order;
  logic [ACC_WIDTH-1:0] snap [NUM_ELEM];
  logic                 overrun_q;

  logic                 xfer;
  logic                 final_xfer;
  logic                 accept;
  logic                 drop;
  logic [3:0]           lin;
  logic [1:0]           map_row;
  logic [1:0]           map_col;

  // Beat-to-PE ordering lives in its own combinational block.
  array_index_map u_index_map (
    .col_major (order),
    .k         (beat),
    .lin       (lin),
    .row       (map_row),
    .col       (map_col)
  );

  // Handshake decode: a new capture is taken in IDLE, or in the very cycle
  // the last beat leaves so back-to-back tiles stream with no bubble. Any
  // other capture while streaming is dropped and flagged.
  always_comb begin
    xfer       = out_valid & out_ready;
    final_xfer = xfer & out_last;
    accept     = capture & ((state == IDLE) | final_xfer);
    drop       = capture & (state == STREAM) & ~final_xfer;
  end

  // Drain FSM and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= 4'd0;
      order <= 1'b0;
    end else if (accept) begin
      state <= STREAM;
      beat  <= 4'd0;
      order <= col_major;
    end else if (xfer) begin
      if (out_last) begin
        state <= IDLE;
        beat  <= 4'd0;
      end else begin
        beat <= beat + 4'd1;
      end
    end
  end

  // Snapshot buffer: loads the whole bus on an accepted capture and is
  // otherwise untouched, so later bus activity cannot leak into a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        snap[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        snap[i] <= array_data_out[ACC_WIDTH*i +: ACC_WIDTH];
      end
    end
  end

  // Sticky overrun flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (clr_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  // Output assembly. The data path is a pure mux of the snapshot, and in
  // reset the buffer and counter are zero, so all outputs read zero without
  // waiting for a clock.
  always_comb begin
    out_valid = (state == STREAM);
    busy      = (state == STREAM);
    out_last  = (state == STREAM) && (beat == 4'd15);
    out_data  = snap[lin];
    out_row   = map_row;
    out_col   = map_col;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_array_result_reader.sv
// Directed bench for array_result_reader: row/column-major drains,
// backpressure with a changing bus, back-to-back captures with overrun,
// asynchronous reset mid-drain and extreme data values.
module tb_array_result_reader;

  localparam int W = 16;

  logic            clk;
  logic            rst_n;
  logic [W*16-1:0] data_bus;
  logic            capture;
  logic            col_major;
  logic [W-1:0]    out_data;
  logic [1:0]      out_row;
  logic [1:0]      out_col;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;
  logic            overrun;
  logic            clr_overrun;

  int checks;
  int errors;

  array_result_reader #(.ACC_WIDTH(W), .ROWS(4), .COLS(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .array_data_out (data_bus),
    .capture        (capture),
    .col_major      (col_major),
    .out_data       (out_data),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .overrun        (overrun),
    .clr_overrun    (clr_overrun)
  );

  // Clock: 10 time-unit period; inputs change and outputs are sampled on the
  // falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W*16-1:0] pack_ramp(input logic [W-1:0] base);
    logic [W*16-1:0] v;
    for (int i = 0; i < 16; i++) begin
      v[W*i +: W] = base + W'(i);
    end
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({out_valid, out_last, busy, overrun, out_data, out_row, out_col} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b b=%b o=%b d=%h r=%0d c=%0d, need all zero",
               out_valid, out_last, busy, overrun, out_data, out_row, out_col);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_row_major();
    logic [W-1:0] exp_d;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL row_idle: got v=%b busy=%b, need 0 0", out_valid, busy);
    end
    data_bus  = pack_ramp(16'h0100);
    col_major = 1'b0;
    out_ready = 1'b1;
    capture   = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_d = 16'h0100 + W'(k);
      checks++;
      if ({out_valid, busy, out_data, out_row, out_col, out_last} !==
          {1'b1, 1'b1, exp_d, 2'(k / 4), 2'(k % 4), (k == 15)}) begin
        errors++;
        $display("FAIL row_beat%0d: got v=%b b=%b d=%h r=%0d c=%0d l=%b, need v=1 b=1 d=%h r=%0d c=%0d l=%0d",
                 k, out_valid, busy, out_data, out_row, out_col, out_last,
                 exp_d, k / 4, k % 4, (k == 15));
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL row_end: got v=%b busy=%b, need 0 0", out_valid, busy);
    end
  endtask

  task automatic test_col_major();
    logic [W-1:0] exp_d;
    int           lin;
    data_bus  = pack_ramp(16'h0100);
    col_major = 1'b1;
    out_ready = 1'b1;
    capture   = 1'b1;
    @(negedge clk);
    capture   = 1'b0;
    col_major = 1'b0;
    for (int k = 0; k < 16; k++) begin
      lin   = (k % 4) * 4 + k / 4;
      exp_d = 16'h0100 + W'(lin);
      checks++;
      if ({out_valid, out_data, out_row, out_col, out_last} !==
          {1'b1, exp_d, 2'(k % 4), 2'(k / 4), (k == 15)}) begin
        errors++;
        $display("FAIL col_beat%0d: got v=%b d=%h r=%0d c=%0d l=%b, need v=1 d=%h r=%0d c=%0d l=%0d",
                 k, out_valid, out_data, out_row, out_col, out_last,
                 exp_d, k % 4, k / 4, (k == 15));
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL col_end: got v=%b, need 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_d;
    int           k;
    int           c;
    data_bus  = pack_ramp(16'h0200);
    col_major = 1'b0;
    out_ready = 1'b1;
    capture   = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    k = 0;
    c = 0;
    while (k < 16 && c < 100) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      for (int i = 0; i < W*16/32; i++) begin
        data_bus[32*i +: 32] = $urandom;
      end
      exp_d = 16'h0200 + W'(k);
      checks++;
      if ({out_valid, out_data, out_row, out_col, out_last} !==
          {1'b1, exp_d, 2'(k / 4), 2'(k % 4), (k == 15)}) begin
        errors++;
        $display("FAIL bp_cycle%0d_beat%0d: got v=%b d=%h r=%0d c=%0d l=%b, need v=1 d=%h r=%0d c=%0d l=%0d",
                 c, k, out_valid, out_data, out_row, out_col, out_last,
                 exp_d, k / 4, k % 4, (k == 15));
      end
      if (out_ready) k++;
      c++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (k != 16 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: got beats=%0d v=%b after %0d cycles, need beats=16 v=0", k, out_valid, c);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_d;
    data_bus    = pack_ramp(16'h0300);
    col_major   = 1'b0;
    out_ready   = 1'b1;
    clr_overrun = 1'b0;
    capture     = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_d = 16'h0300 + W'(k);
      checks++;
      if ({out_valid, out_data, out_last} !== {1'b1, exp_d, (k == 15)}) begin
        errors++;
        $display("FAIL b2b_first_beat%0d: got v=%b d=%h l=%b, need v=1 d=%h l=%0d",
                 k, out_valid, out_data, out_last, exp_d, (k == 15));
      end
      if (k == 4) begin
        checks++;
        if (overrun !== 1'b1) begin
          errors++;
          $display("FAIL b2b_overrun_set: got %b, need 1", overrun);
        end
      end
      capture = (k >= 3);
      if (k == 15) data_bus = pack_ramp(16'hA000);
      @(negedge clk);
    end
    capture = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_d = 16'hA000 + W'(k);
      checks++;
      if ({out_valid, out_data, out_row, out_col, out_last} !==
          {1'b1, exp_d, 2'(k / 4), 2'(k % 4), (k == 15)}) begin
        errors++;
        $display("FAIL b2b_second_beat%0d: got v=%b d=%h r=%0d c=%0d l=%b, need v=1 d=%h r=%0d c=%0d l=%0d",
                 k, out_valid, out_data, out_row, out_col, out_last,
                 exp_d, k / 4, k % 4, (k == 15));
      end
      capture     = 1'b0;
      clr_overrun = 1'b0;
      if (k == 0 || k == 6) begin
        checks++;
        if (overrun !== 1'b1) begin
          errors++;
          $display("FAIL b2b_overrun_k%0d: got %b, need 1", k, overrun);
        end
      end
      if (k == 2 || k == 7) begin
        checks++;
        if (overrun !== 1'b0) begin
          errors++;
          $display("FAIL b2b_overrun_clear_k%0d: got %b, need 0", k, overrun);
        end
      end
      if (k == 1 || k == 6) clr_overrun = 1'b1;
      if (k == 5) begin
        capture     = 1'b1;
        clr_overrun = 1'b1;
      end
      @(negedge clk);
    end
    capture     = 1'b0;
    clr_overrun = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got v=%b busy=%b, need 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_drain();
    int valid_seen;
    data_bus  = pack_ramp(16'h0400);
    col_major = 1'b0;
    out_ready = 1'b1;
    capture   = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0400 + W'(k)) begin
        errors++;
        $display("FAIL rst_pre_beat%0d: got v=%b d=%h, need v=1 d=%h",
                 k, out_valid, out_data, 16'h0400 + W'(k));
      end
      if (k < 7) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, busy, overrun, out_data, out_row, out_col} !== '0) begin
      errors++;
      $display("FAIL rst_async: got v=%b l=%b b=%b o=%b d=%h r=%0d c=%0d, need all zero",
               out_valid, out_last, busy, overrun, out_data, out_row, out_col);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) valid_seen++;
    end
    checks++;
    if (valid_seen != 0) begin
      errors++;
      $display("FAIL rst_idle: got %0d cycles with valid/busy, need 0", valid_seen);
    end
  endtask

  task automatic test_edge_values();
    logic [W-1:0] exp_d;
    int           lin;
    for (int i = 0; i < 16; i++) data_bus[W*i +: W] = 16'h1234;
    data_bus[0 +: W]    = 16'hFFFF;
    data_bus[W*15 +: W] = 16'h8000;
    col_major = 1'b1;
    out_ready = 1'b1;
    capture   = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    for (int k = 0; k < 16; k++) begin
      lin   = (k % 4) * 4 + k / 4;
      exp_d = (lin == 0) ? 16'hFFFF : (lin == 15) ? 16'h8000 : 16'h1234;
      checks++;
      if ({out_valid, out_data, out_row, out_col, out_last} !==
          {1'b1, exp_d, 2'(lin / 4), 2'(lin % 4), (k == 15)}) begin
        errors++;
        $display("FAIL edge_beat%0d: got v=%b d=%h r=%0d c=%0d l=%b, need v=1 d=%h r=%0d c=%0d l=%0d",
                 k, out_valid, out_data, out_row, out_col, out_last,
                 exp_d, lin / 4, lin % 4, (k == 15));
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL edge_end: got v=%b, need 0", out_valid);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    data_bus    = '0;
    capture     = 1'b0;
    col_major   = 1'b0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    test_reset();
    test_row_major();
    test_col_major();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    test_edge_values();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
